spi_xfer_sched: RTL and testbench

Round-robin transfer scheduler that shares the single SPI master datapath (shift, clock and slave-select logic) between several on-chip requesters. It accepts one word per request, drives the SPI core's start/complete handshake, selects the target slave, returns the received word to the owning requester, and enforces a programmable slave-deselect gap between consecutive transfers. It sits between the requester ports and the SPI control/shift path, in the `pclk` domain.

---
 rtl/spi_xfer_sched.sv | 145 ++++++++++++++
 tb/tb_spi_xfer_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one SPI master datapath between requesters.
// Grants one word per request and enforces a slave-deselect gap afterwards.
module spi_xfer_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int GAP_W   = 8,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      spi_enable,
  input  logic [GAP_W-1:0]          gap_cycles,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [2*NUM_REQ-1:0]      req_ss,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [DATA_W-1:0]         transfer_data,
  output logic [1:0]                slave_select,
  output logic                      slave_ena,
  output logic                      transfer_start,
  input  logic                      transfer_start_ack,
  input  logic                      transfer_complete,
  output logic                      transfer_complete_ack,
  input  logic [DATA_W-1:0]         receive_data,
  output logic                      busy,
  output logic [OWN_W-1:0]          owner
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACK,
    GAP
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [OWN_W-1:0]   rr_ptr;
  logic [OWN_W-1:0]   win;
  logic [OWN_W:0]     idx;
  logic               found;
  logic               grant;
  logic               cap;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_REQ-1:0] own_oh;

  // search upward from rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (OWN_W+1)'(k);
      if (idx >= (OWN_W+1)'(NUM_REQ))
        idx = idx - (OWN_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[OWN_W-1:0]]) begin
        found = 1'b1;
        win   = idx[OWN_W-1:0];
      end
    end
  end

  assign grant = (state == IDLE) && spi_enable && found;

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  assign cap = transfer_complete &&
               ((state == WAIT) ||
                (state == START && transfer_start_ack));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (grant)
          state_n = START;
      START:
        if (transfer_start_ack)
          state_n = transfer_complete ? ACK : WAIT;
      WAIT:
        if (transfer_complete)
          state_n = ACK;
      ACK:
        state_n = (gap_cycles != '0) ? GAP : IDLE;
      GAP:
        if (gap_cnt == GAP_W'(1))
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state                 <= IDLE;
      rr_ptr                <= '0;
      owner                 <= '0;
      transfer_data         <= '0;
      slave_select          <= '0;
      rsp_rdata             <= '0;
      gap_cnt               <= '0;
      transfer_start        <= 1'b0;
      slave_ena             <= 1'b0;
      transfer_complete_ack <= 1'b0;
      busy                  <= 1'b0;
      rsp_valid             <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        transfer_data <= req_wdata[DATA_W*win +: DATA_W];
        slave_select  <= req_ss[2*win +: 2];
        owner         <= win;
        rr_ptr        <= (win == OWN_W'(NUM_REQ-1)) ?
                         '0 : win + OWN_W'(1);
      end
      if (cap)
        rsp_rdata <= receive_data;
      if (state == ACK)
        gap_cnt <= gap_cycles;
      else if (state == GAP)
        gap_cnt <= gap_cnt - GAP_W'(1);
      // outputs decoded from the next state so they line up with it
      transfer_start        <= (state_n == START);
      slave_ena             <= (state_n == START) ||
                               (state_n == WAIT) ||
                               (state_n == ACK);
      transfer_complete_ack <= (state_n == ACK);
      busy                  <= (state_n != IDLE);
      rsp_valid             <= (state_n == ACK) ? own_oh : '0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched: 4-requester instance plus a
// 3-requester instance for the non-power-of-two wrap.
module tb_spi_xfer_sched;

  logic         pclk;
  logic         preset;
  logic         spi_enable;
  logic [7:0]   gap_cycles;
  logic [3:0]   req_valid;
  logic [7:0]   req_ss;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic [31:0]  transfer_data;
  logic [1:0]   slave_select;
  logic         slave_ena;
  logic         transfer_start;
  logic         transfer_start_ack;
  logic         transfer_complete;
  logic         transfer_complete_ack;
  logic [31:0]  receive_data;
  logic         busy;
  logic [1:0]   owner;

  logic         auto_core;
  logic         man_ack;
  logic         man_cmp;

  logic [2:0]   r3_valid;
  logic [2:0]   r3_ready;
  logic [2:0]   r3_rsp;
  logic [31:0]  r3_rdata;
  logic [31:0]  r3_tdata;
  logic [1:0]   r3_ss_o;
  logic         r3_sena;
  logic         r3_start;
  logic         r3_cack;
  logic         r3_busy;
  logic [1:0]   r3_owner;

  int total;
  int bad;

  assign transfer_start_ack = auto_core ? transfer_start : man_ack;
  assign transfer_complete  = auto_core ?
    (slave_ena & ~transfer_start & ~transfer_complete_ack) : man_cmp;

  spi_xfer_sched dut (
    .pclk                  (pclk),
    .preset                (preset),
    .spi_enable            (spi_enable),
    .gap_cycles            (gap_cycles),
    .req_valid             (req_valid),
    .req_ss                (req_ss),
    .req_wdata             (req_wdata),
    .req_ready             (req_ready),
    .rsp_valid             (rsp_valid),
    .rsp_rdata             (rsp_rdata),
    .transfer_data         (transfer_data),
    .slave_select          (slave_select),
    .slave_ena             (slave_ena),
    .transfer_start        (transfer_start),
    .transfer_start_ack    (transfer_start_ack),
    .transfer_complete     (transfer_complete),
    .transfer_complete_ack (transfer_complete_ack),
    .receive_data          (receive_data),
    .busy                  (busy),
    .owner                 (owner)
  );

  spi_xfer_sched #(.NUM_REQ(3)) dut3 (
    .pclk                  (pclk),
    .preset                (preset),
    .spi_enable            (1'b1),
    .gap_cycles            (8'd1),
    .req_valid             (r3_valid),
    .req_ss                (6'b10_01_00),
    .req_wdata             ({32'h3333_0002, 32'h3333_0001, 32'h3333_0000}),
    .req_ready             (r3_ready),
    .rsp_valid             (r3_rsp),
    .rsp_rdata             (r3_rdata),
    .transfer_data         (r3_tdata),
    .slave_select          (r3_ss_o),
    .slave_ena             (r3_sena),
    .transfer_start        (r3_start),
    .transfer_start_ack    (r3_start),
    .transfer_complete     (r3_sena & ~r3_start & ~r3_cack),
    .transfer_complete_ack (r3_cack),
    .receive_data          (32'h0BAD_F00D),
    .busy                  (r3_busy),
    .owner                 (r3_owner)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, {owner, slave_select, slave_ena, busy,
                        transfer_start, transfer_complete_ack,
                        req_ready, rsp_valid}, 64'h0);
    check({tag, "_b"}, {transfer_data, rsp_rdata}, 64'h0);
  endtask

  logic [3:0] grants [8];
  int         gcyc [8];
  logic [2:0] g3 [8];
  int         n;
  int         g;
  int         pend;
  int         leak;
  int         n_cack;
  int         n_rsp;
  int         bad_own;

  initial begin
    total      = 0;
    bad        = 0;
    preset     = 1'b1;
    spi_enable = 1'b0;
    gap_cycles = 8'd0;
    req_valid  = 4'h0;
    req_ss     = 8'h00;
    req_wdata  = '0;
    auto_core  = 1'b0;
    man_ack    = 1'b0;
    man_cmp    = 1'b0;
    receive_data = 32'h0;
    r3_valid   = 3'b000;
    req_wdata[31:0]   = 32'hA5A5_0001;
    req_wdata[63:32]  = 32'hA5A5_0011;
    req_wdata[95:64]  = 32'hA5A5_0022;
    req_wdata[127:96] = 32'hA5A5_0033;
    #12;
    check_zero("reset");
    tick();
    preset = 1'b0;
    tick();

    // single request
    spi_enable = 1'b1;
    gap_cycles = 8'd3;
    req_ss     = 8'b11_00_01_10;
    req_valid  = 4'b0001;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check("t1_ss", slave_select, 2'd2);
    check("t1_tdata", transfer_data, 32'hA5A5_0001);
    check("t1_ena_busy", {slave_ena, busy}, 2'b11);
    n = 0;
    while (transfer_start && n < 20) begin
      n++;
      if (n == 3) man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
    end
    check("t1_start_len", n, 3);
    check("t1_wait", {slave_ena, transfer_start, rsp_valid}, 6'b10_0000);
    man_cmp      = 1'b1;
    receive_data = 32'h1234_5678;
    tick();
    man_cmp = 1'b0;
    check("t1_rsp", {transfer_complete_ack, rsp_valid}, 5'b1_0001);
    check("t1_rdata", rsp_rdata, 32'h1234_5678);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy && !slave_ena) n++;
      else break;
    end
    check("t1_gap_len", n, 3);
    check("t1_idle", {busy, rsp_valid}, 5'b0);
    check("t1_hold", rsp_rdata, 32'h1234_5678);

    // round-robin, immediate core
    do_reset();
    auto_core  = 1'b1;
    gap_cycles = 8'd0;
    req_valid  = 4'b1111;
    g    = 0;
    pend = -1;
    for (int c = 0; c < 60 && g < 5; c++) begin
      @(negedge pclk);
      if (pend >= 0) begin
        check("rr_owner", owner, pend);
        pend = -1;
      end
      if (req_ready != 4'b0) begin
        grants[g] = req_ready;
        gcyc[g]   = c;
        pend = (req_ready[1] ? 1 : 0) + (req_ready[2] ? 2 : 0) +
               (req_ready[3] ? 3 : 0);
        g++;
      end
    end
    req_valid = 4'b0000;
    check("rr_count", g, 5);
    check("rr_g0", grants[0], 4'b0001);
    check("rr_g1", grants[1], 4'b0010);
    check("rr_g2", grants[2], 4'b0100);
    check("rr_g3", grants[3], 4'b1000);
    check("rr_g4", grants[4], 4'b0001);
    for (int i = 0; i < 4; i++)
      check("rr_space", gcyc[i+1] - gcyc[i], 4);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("rr_drain", busy, 1'b0);
    auto_core = 1'b0;

    // start ack and complete in the same cycle
    do_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    check("t3_start", transfer_start, 1'b1);
    man_ack      = 1'b1;
    man_cmp      = 1'b1;
    receive_data = 32'hCAFE_F00D;
    tick();
    man_ack = 1'b0;
    man_cmp = 1'b0;
    check("t3_ack", {transfer_complete_ack, rsp_valid}, 5'b1_0010);
    check("t3_rdata", rsp_rdata, 32'hCAFE_F00D);
    n_cack = 1;
    n_rsp  = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cack += int'(transfer_complete_ack);
      n_rsp  += int'(rsp_valid != 4'b0);
    end
    check("t3_cack_n", n_cack, 1);
    check("t3_rsp_n", n_rsp, 1);

    // enable drop during WAIT
    do_reset();
    req_valid = 4'b0110;
    #1;
    check("t4_ready", req_ready, 4'b0010);
    tick();
    man_ack = 1'b1;
    tick();
    man_ack    = 1'b0;
    spi_enable = 1'b0;
    tick();
    man_cmp      = 1'b1;
    receive_data = 32'h0000_BEEF;
    tick();
    man_cmp = 1'b0;
    check("t4_rsp", rsp_valid, 4'b0010);
    check("t4_rdata", rsp_rdata, 32'h0000_BEEF);
    leak = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (req_ready != 4'b0 || busy) leak++;
    end
    check("t4_no_grant", leak, 0);
    spi_enable = 1'b1;
    #1;
    check("t4_next", req_ready, 4'b0100);
    req_valid = 4'b0000;

    // reset during WAIT
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    man_ack   = 1'b1;
    tick();
    man_ack = 1'b0;
    check("t5_wait", {busy, slave_ena, transfer_start}, 3'b110);
    #2;
    preset = 1'b1;
    #1;
    check_zero("t5_async");
    tick();
    preset = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rsp_valid != 4'b0 || busy) n++;
    end
    check("t5_quiet", n, 0);
    req_valid = 4'b1000;
    #1;
    check("t5_ready3", req_ready, 4'b1000);
    req_valid = 4'b1001;
    #1;
    check("t5_ptr0", req_ready, 4'b0001);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    check("t5_owner", owner, 2'd3);

    // three requesters
    do_reset();
    r3_valid = 3'b111;
    g       = 0;
    bad_own = 0;
    for (int c = 0; c < 80 && g < 4; c++) begin
      @(negedge pclk);
      if (r3_owner == 2'd3) bad_own++;
      if (r3_ready != 3'b0) begin
        g3[g] = r3_ready;
        g++;
      end
    end
    r3_valid = 3'b000;
    check("w3_count", g, 4);
    check("w3_g0", g3[0], 3'b001);
    check("w3_g1", g3[1], 3'b010);
    check("w3_g2", g3[2], 3'b100);
    check("w3_g3", g3[3], 3'b001);
    check("w3_owner", bad_own, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
